// File: rtl/conv_maxpool.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | conv_maxpool : optional ReLU + non-overlapping 2x2 max-pool on a raster   |
// |                conv result stream, half-width line buffer.                |
// | Macro CONV_MAXPOOL_RELU_EN clamps negative samples to 0 before pooling.   |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module conv_maxpool #(
  parameter int DATA_W = 16,
  parameter int IMG_W  = 6,
  parameter int IMG_H  = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] din,
  output logic                     pool_valid,
  output logic signed [DATA_W-1:0] pool_dout,
  output logic                     pool_last,
  output logic                     frame_done,
  output logic                     busy
);

  localparam int c_CW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int c_RW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int c_LB_D  = IMG_W / 2;
  localparam int c_LB_AW = (c_LB_D > 1) ? $clog2(c_LB_D) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  generate
    if ((IMG_W % 2) != 0 || (IMG_H % 2) != 0 || IMG_W < 2 || IMG_H < 2) begin : g_param_check
      $error("conv_maxpool: IMG_W and IMG_H must be even and at least 2");
    end
  endgenerate

  logic [1:0]               r_state, w_next_state;
  logic [c_CW-1:0]          r_col;
  logic [c_RW-1:0]          r_row;
  logic                     w_last_col, w_last_row, w_last_pix;
  logic signed [DATA_W-1:0] w_s, r_h, w_hmax, w_lb_rd, w_vmax;
  logic signed [DATA_W-1:0] r_linebuf [c_LB_D];
  logic [c_LB_AW-1:0]       w_lb_idx;
  logic                     w_busy, w_in_done;

  assign w_last_col = (r_col == c_CW'(IMG_W - 1));
  assign w_last_row = (r_row == c_RW'(IMG_H - 1));
  assign w_last_pix = w_last_col && w_last_row;

`ifdef CONV_MAXPOOL_RELU_EN
  assign w_s = din[DATA_W-1] ? '0 : din;
`else
  assign w_s = din;
`endif

  assign w_hmax   = (r_h > w_s) ? r_h : w_s;
  assign w_lb_idx = c_LB_AW'(r_col >> 1);
  assign w_lb_rd  = r_linebuf[w_lb_idx];
  assign w_vmax   = (w_lb_rd > w_hmax) ? w_lb_rd : w_hmax;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // FSM: next state; a sample in DONE starts the next frame without a gap
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_next_state = S_RUN;
      S_RUN:   if (in_valid && w_last_pix) w_next_state = S_DONE;
      S_DONE:  w_next_state = in_valid ? S_RUN : S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    w_busy    = 1'b0;
    w_in_done = 1'b0;
    case (r_state)
      S_RUN:   w_busy    = 1'b1;
      S_DONE:  w_in_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_col <= '0;
      r_row <= '0;
    end else if (in_valid) begin
      if (w_last_col) begin
        r_col <= '0;
        r_row <= w_last_row ? '0 : r_row + c_RW'(1);
      end else begin
        r_col <= r_col + c_CW'(1);
      end
    end
  end

  // Datapath storage needs no reset: every entry is written before it is read
  always_ff @(posedge clk) begin
    if (in_valid) begin
      if (!r_col[0]) r_h <= w_s;
      if (r_col[0] && !r_row[0]) r_linebuf[w_lb_idx] <= w_hmax;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pool_valid <= 1'b0;
      pool_dout  <= '0;
      pool_last  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      pool_valid <= in_valid && r_col[0] && r_row[0];
      pool_last  <= in_valid && w_last_pix;
      frame_done <= w_in_done;
      if (in_valid && r_col[0] && r_row[0]) pool_dout <= w_vmax;
    end
  end

  assign busy = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_conv_maxpool.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_conv_maxpool : directed self-checking bench for conv_maxpool.          |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_conv_maxpool;

  localparam int c_W = 6;
  localparam int c_H = 6;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] din;
  logic        pool_valid, pool_last, frame_done, busy;
  logic [15:0] pool_dout;

  conv_maxpool #(.DATA_W(16), .IMG_W(c_W), .IMG_H(c_H)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .din(din),
    .pool_valid(pool_valid), .pool_dout(pool_dout), .pool_last(pool_last),
    .frame_done(frame_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int          n_assert = 0;
  int          n_fail   = 0;
  int          n_strobe = 0;
  logic [15:0] exp_q[$];
  int          bcol = 0, brow = 0;
  logic        pend_v = 0, pend_l = 0, pend_fd = 0, pend_busy = 0;
  logic [15:0] pend_d = 0;
  int          c_ramp[9] = '{7, 9, 11, 19, 21, 23, 31, 33, 35};

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s @%0t: observed %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic check_pending();
    chk("pool_valid", {15'b0, pool_valid}, {15'b0, pend_v});
    chk("pool_dout",  pool_dout, pend_d);
    chk("pool_last",  {15'b0, pool_last}, {15'b0, pend_l});
    chk("frame_done", {15'b0, frame_done}, {15'b0, pend_fd});
    chk("busy",       {15'b0, busy}, {15'b0, pend_busy});
    if (pool_valid === 1'b1) n_strobe++;
  endtask

  // One cycle: check results of the previous edge, then drive the next input
  task automatic tick(input logic v, input int d);
    @(negedge clk);
    check_pending();
    rst_n    = 1'b1;
    in_valid = v;
    din      = 16'(d);
    pend_fd  = pend_l;
    pend_v   = v && brow[0] && bcol[0];
    pend_l   = v && (brow == c_H - 1) && (bcol == c_W - 1);
    if (pend_v) begin
      if (exp_q.size() > 0) pend_d = exp_q.pop_front();
      else chk("exp_queue_underrun", 16'd0, 16'd1);
    end
    if (v) begin
      if (bcol == c_W - 1) begin
        bcol = 0;
        brow = (brow == c_H - 1) ? 0 : brow + 1;
      end else begin
        bcol = bcol + 1;
      end
    end
    pend_busy = (bcol != 0) || (brow != 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    check_pending();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    din      = 16'h0;
    {pend_v, pend_l, pend_fd, pend_busy} = 4'b0;
    pend_d = 16'h0;
    bcol   = 0;
    brow   = 0;
  endtask

  // mode 0: ramp from base; mode 1: all FFFF with 8000 at row1/col1
  task automatic send(input int mode, input int base, input int n, input bit gap);
    for (int i = 0; i < n; i++) begin
      tick(1'b1, (mode == 0) ? base + i : ((i == 7) ? 32'h8000 : 32'hFFFF));
      if (gap) tick(1'b0, 32'h5A5A);
    end
  endtask

  task automatic push_ramp(input int off, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(16'(c_ramp[i] + off));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 0);
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    din      = 16'h0;
    do_reset();
    do_reset();

    // ramp
    push_ramp(0, 9);
    send(0, 0, 36, 1'b0);
    idle(3);

    // signed compare
`ifdef CONV_MAXPOOL_RELU_EN
    for (int i = 0; i < 9; i++) exp_q.push_back(16'h0000);
`else
    for (int i = 0; i < 9; i++) exp_q.push_back(16'hFFFF);
`endif
    send(1, 0, 36, 1'b0);
    idle(2);

    // ramp minus 20
`ifdef CONV_MAXPOOL_RELU_EN
    foreach (c_ramp[i]) exp_q.push_back((c_ramp[i] < 20) ? 16'd0 : 16'(c_ramp[i] - 20));
`else
    push_ramp(-20, 9);
`endif
    send(0, -20, 36, 1'b0);
    idle(2);

    // bubbles
    push_ramp(0, 9);
    send(0, 0, 36, 1'b1);
    idle(2);

    // reset mid-frame after 20 samples: only windows completed before reset
    push_ramp(0, 4);
    send(0, 0, 20, 1'b0);
    do_reset();
    push_ramp(0, 9);
    send(0, 0, 36, 1'b0);
    idle(2);

    // back-to-back frames
    push_ramp(0, 9);
    push_ramp(100, 9);
    send(0, 0, 36, 1'b0);
    send(0, 100, 36, 1'b0);
    idle(4);

    chk("exp_queue_empty", 16'(exp_q.size()), 16'd0);
    chk("strobe_count", 16'(n_strobe), 16'd67);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
